// File: rtl/rsp_s2_prep_ahb_pkg.sv
// Shared definitions for the AHB register slave: FSM states, response and size codes.
package rsp_s2_prep_ahb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  localparam logic [2:0] SIZE_BYTE = 3'b000;
  localparam logic [2:0] SIZE_HALF = 3'b001;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  localparam int IDX_W = 6;

  // True when the access does not sit on its natural size boundary.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] lsb);
    return ((size == SIZE_HALF) && lsb[0]) || ((size == SIZE_WORD) && (lsb != 2'b00));
  endfunction

endpackage

// File: rtl/rsp_s2_prep_ahbslv_bytemask.sv
// Maps transfer size and address[1:0] to little-endian byte enables.
module rsp_s2_prep_ahbslv_bytemask
  import rsp_s2_prep_ahb_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lsb,
  output logic [3:0] byte_en
);

  // Byte selects one lane, halfword selects the lower or upper pair, word selects all.
  always_comb begin
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << addr_lsb;
      SIZE_HALF: byte_en = addr_lsb[1] ? 4'b1100 : 4'b0011;
      default:   byte_en = 4'b1111;
    endcase
  end

endmodule

// File: rtl/rsp_s2_prep_ahbslv_regs.sv
// AHB-Lite register slave: NUM_RW config registers, NUM_RO status registers,
// optional wait states and a two-cycle ERROR response.
//
// state   | meaning
// IDLE    | ready; completes a pending OKAY transfer, accepts a new address phase
// WAIT    | data-phase wait cycles, counter counts down to 0
// ERR1    | first ERROR cycle, HREADYOUTM low
// ERR2    | second ERROR cycle, HREADYOUTM high, may accept a new address phase
module rsp_s2_prep_ahbslv_regs
  import rsp_s2_prep_ahb_pkg::*;
#(
  parameter int WAIT_STATES = 0,
  parameter int NUM_RW      = 12,
  parameter int NUM_RO      = 4
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 HSELM,
  input  logic [31:0]          HADDRM,
  input  logic [1:0]           HTRANSM,
  input  logic                 HWRITEM,
  input  logic [2:0]           HSIZEM,
  input  logic [31:0]          HWDATAM,
  input  logic                 HREADYMUXM,
  output logic                 HREADYOUTM,
  output logic                 HRESPM,
  output logic [31:0]          HRDATAM,
  input  logic [NUM_RO*32-1:0] status_in,
  output logic [NUM_RW*32-1:0] cfg_out,
  output logic [NUM_RW-1:0]    cfg_wr_pulse
);

  localparam int NUM_REGS = NUM_RW + NUM_RO;
  localparam logic [1:0] WAIT_LOAD = 2'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t           state;
  logic [1:0]       wait_cnt;
  logic             pend;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lsb_q;
  logic [2:0]       size_q;
  logic             wr_q;
  logic             accept;
  logic             acc_err;
  logic             wr_fire;
  logic [3:0]       byte_en;
  logic [31:0]      rd_word;
  logic [31:0]      regs [NUM_RW];
  logic             unused_bus_bits;

  assign unused_bus_bits = ^{HADDRM[31:8], HTRANSM[0]};

  // A new address phase is only taken while the slave is presenting HREADYOUTM high.
  assign accept = HSELM & HTRANSM[1] & HREADYMUXM & ((state == ST_IDLE) | (state == ST_ERR2));

  // Error classification of the address phase being accepted.
  always_comb begin
    acc_err = 1'b0;
    if (32'(HADDRM[7:2]) >= NUM_REGS)              acc_err = 1'b1;
    if (HSIZEM > SIZE_WORD)                        acc_err = 1'b1;
    if (is_misaligned(HSIZEM, HADDRM[1:0]))        acc_err = 1'b1;
    if (HWRITEM && (32'(HADDRM[7:2]) >= NUM_RW))   acc_err = 1'b1;
  end

  // Transfer FSM with registered ready/response; pend marks the completion cycle.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      pend       <= 1'b0;
      HREADYOUTM <= 1'b1;
      HRESPM     <= RESP_OKAY;
      idx_q      <= '0;
      lsb_q      <= '0;
      size_q     <= SIZE_BYTE;
      wr_q       <= 1'b0;
    end else begin
      pend <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state      <= ST_IDLE;
            pend       <= 1'b1;
            HREADYOUTM <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_ERR1: begin
          state      <= ST_ERR2;
          HREADYOUTM <= 1'b1;
          HRESPM     <= RESP_ERROR;
        end
        default: begin
          state      <= ST_IDLE;
          HREADYOUTM <= 1'b1;
          HRESPM     <= RESP_OKAY;
          if (accept) begin
            idx_q  <= HADDRM[7:2];
            lsb_q  <= HADDRM[1:0];
            size_q <= HSIZEM;
            wr_q   <= HWRITEM;
            if (acc_err) begin
              state      <= ST_ERR1;
              HREADYOUTM <= 1'b0;
              HRESPM     <= RESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state      <= ST_WAIT;
              wait_cnt   <= WAIT_LOAD;
              HREADYOUTM <= 1'b0;
            end else begin
              pend <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign wr_fire = pend & wr_q;

  rsp_s2_prep_ahbslv_bytemask u_bytemask (
    .size     (size_q),
    .addr_lsb (lsb_q),
    .byte_en  (byte_en)
  );

  // Byte-lane merge of write data into the addressed RW register at completion.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < NUM_RW; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx_q == IDX_W'(i)) begin
          for (int b = 0; b < 4; b++) begin
            if (byte_en[b]) regs[i][b*8 +: 8] <= HWDATAM[b*8 +: 8];
          end
        end
      end
    end
  end

  // Write strobe is visible during the completion cycle itself.
  always_comb begin
    cfg_wr_pulse = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (wr_fire && (idx_q == IDX_W'(i))) cfg_wr_pulse[i] = 1'b1;
    end
  end

  // Read mux reads live register state so a write just completed is seen by a back-to-back read.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (idx_q == IDX_W'(i)) rd_word = regs[i];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (idx_q == IDX_W'(NUM_RW + k)) rd_word = status_in[k*32 +: 32];
    end
  end

  assign HRDATAM = (pend && !wr_q) ? rd_word : '0;

  // Flatten RW registers onto the configuration bus.
  always_comb begin
    for (int i = 0; i < NUM_RW; i++) cfg_out[i*32 +: 32] = regs[i];
  end

endmodule

// File: tb/tb_rsp_s2_prep_ahbslv_regs.sv
// Directed bench: one slave with no wait states, one with two, sharing the bus inputs.
module tb_rsp_s2_prep_ahbslv_regs;

  typedef struct {
    string       tag;
    bit          err;
    bit          wr;
    logic [31:0] rd;
    int          waits;
    logic [11:0] pulse;
  } exp_t;

  logic         HCLK = 1'b0;
  logic         HRESET;
  logic [1:0]   sel;
  logic [31:0]  HADDRM;
  logic [1:0]   HTRANSM;
  logic         HWRITEM;
  logic [2:0]   HSIZEM;
  logic [31:0]  HWDATAM;
  logic [127:0] status_in;
  logic [1:0]   rdy;
  logic [1:0]   resp;
  logic [31:0]  rdata [2];
  logic [383:0] cfg   [2];
  logic [11:0]  pulse [2];

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 HCLK = ~HCLK;

  rsp_s2_prep_ahbslv_regs #(.WAIT_STATES(0), .NUM_RW(12), .NUM_RO(4)) dut_w0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSELM(sel[0]), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
    .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HWDATAM(HWDATAM), .HREADYMUXM(rdy[0]),
    .HREADYOUTM(rdy[0]), .HRESPM(resp[0]), .HRDATAM(rdata[0]), .status_in(status_in),
    .cfg_out(cfg[0]), .cfg_wr_pulse(pulse[0])
  );

  rsp_s2_prep_ahbslv_regs #(.WAIT_STATES(2), .NUM_RW(12), .NUM_RO(4)) dut_w2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSELM(sel[1]), .HADDRM(HADDRM), .HTRANSM(HTRANSM),
    .HWRITEM(HWRITEM), .HSIZEM(HSIZEM), .HWDATAM(HWDATAM), .HREADYMUXM(rdy[1]),
    .HREADYOUTM(rdy[1]), .HRESPM(resp[1]), .HRDATAM(rdata[1]), .status_in(status_in),
    .cfg_out(cfg[1]), .cfg_wr_pulse(pulse[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_bus();
    sel     = 2'b00;
    HTRANSM = 2'b00;
  endtask

  task automatic addr_phase(input int d, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                            input bit err, input logic [31:0] rd, input string tag);
    exp_t e;
    sel       = 2'b00;
    sel[d]    = 1'b1;
    HTRANSM   = 2'b10;
    HADDRM    = addr;
    HWRITEM   = wr;
    HSIZEM    = size;
    e.tag     = tag;
    e.err     = err;
    e.wr      = wr;
    e.rd      = rd;
    e.waits   = err ? 1 : ((d == 1) ? 2 : 0);
    e.pulse   = '0;
    if (wr && !err) e.pulse[addr[7:2]] = 1'b1;
    sb.push_back(e);
  endtask

  task automatic complete(input int d);
    exp_t e;
    int   n = 0;
    @(negedge HCLK);
    while (rdy[d] !== 1'b1 && n < 8) begin
      check({sb[0].tag, "_wait_resp"}, 32'(resp[d]), 32'(sb[0].err));
      check({sb[0].tag, "_wait_rdata"}, rdata[d], 32'h0);
      n++;
      @(negedge HCLK);
    end
    e = sb.pop_front();
    check({e.tag, "_waits"}, 32'(n), 32'(e.waits));
    check({e.tag, "_resp"}, 32'(resp[d]), 32'(e.err));
    check({e.tag, "_rdata"}, rdata[d], (e.err || e.wr) ? 32'h0 : e.rd);
    check({e.tag, "_pulse"}, 32'(pulse[d]), 32'(e.pulse));
  endtask

  task automatic xfer(input int d, input logic [31:0] addr, input bit wr, input logic [2:0] size,
                      input logic [31:0] wdata, input bit err, input logic [31:0] rd, input string tag);
    addr_phase(d, addr, wr, size, err, rd, tag);
    cyc();
    idle_bus();
    HWDATAM = wdata;
    complete(d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET    = 1'b1;
    sel       = 2'b00;
    HADDRM    = '0;
    HTRANSM   = 2'b00;
    HWRITEM   = 1'b0;
    HSIZEM    = 3'b010;
    HWDATAM   = '0;
    status_in = {32'h0BAD_0015, 32'h0BAD_0014, 32'h1234_5678, 32'hCAFE_0012};
    repeat (3) cyc();
    HRESET = 1'b0;

    @(negedge HCLK);
    check("rst_ready_w0", 32'(rdy[0]), 32'h1);
    check("rst_ready_w2", 32'(rdy[1]), 32'h1);
    check("rst_resp_w2", 32'(resp[1]), 32'h0);
    check("rst_rdata_w2", rdata[1], 32'h0);
    check("rst_cfg_lo_w2", cfg[1][31:0], 32'h0);
    check("rst_cfg_r2_w0", cfg[0][95:64], 32'h0);
    check("rst_pulse_w2", 32'(pulse[1]), 32'h0);

    // Two wait states, word write then the strobe must be gone the following cycle.
    xfer(1, 32'h08, 1'b1, 3'b010, 32'hDEADBEEF, 1'b0, 32'h0, "w2_wr08");
    cyc();
    @(negedge HCLK);
    check("w2_pulse_after", 32'(pulse[1]), 32'h0);
    check("w2_cfg_r2", cfg[1][95:64], 32'hDEADBEEF);
    xfer(1, 32'h08, 1'b0, 3'b010, 32'h0, 1'b0, 32'hDEADBEEF, "w2_rd08");

    // Zero waits: byte write with junk in unused lanes, then back-to-back word read.
    xfer(0, 32'h05, 1'b1, 3'b000, 32'h1122AB44, 1'b0, 32'h0, "w0_wrb05");
    xfer(0, 32'h04, 1'b0, 3'b010, 32'h0, 1'b0, 32'h0000AB00, "w0_rd04");

    // Error responses, each next transfer accepted during ERR2.
    xfer(0, 32'h30, 1'b1, 3'b010, 32'hFFFFFFFF, 1'b1, 32'h0, "w0_wr_ro30");
    xfer(0, 32'h30, 1'b0, 3'b010, 32'h0, 1'b0, 32'hCAFE0012, "w0_rd30");
    xfer(0, 32'h03, 1'b0, 3'b001, 32'h0, 1'b1, 32'h0, "w0_rdh03");
    xfer(0, 32'h34, 1'b0, 3'b010, 32'h0, 1'b0, 32'h12345678, "w0_rd34");
    xfer(0, 32'h00, 1'b0, 3'b011, 32'h0, 1'b1, 32'h0, "w0_size3");
    xfer(0, 32'h40, 1'b0, 3'b010, 32'h0, 1'b1, 32'h0, "w0_rd40");

    // Halfword and byte merges, misaligned write must not disturb anything.
    xfer(0, 32'h0A, 1'b1, 3'b001, 32'hBEEF1111, 1'b0, 32'h0, "w0_wrh0a");
    xfer(0, 32'h08, 1'b0, 3'b010, 32'h0, 1'b0, 32'hBEEF0000, "w0_rd08");
    xfer(0, 32'h07, 1'b1, 3'b000, 32'h5A334455, 1'b0, 32'h0, "w0_wrb07");
    xfer(0, 32'h06, 1'b1, 3'b010, 32'h77777777, 1'b1, 32'h0, "w0_wr_mis06");
    xfer(0, 32'h04, 1'b0, 3'b010, 32'h0, 1'b0, 32'h5A00AB00, "w0_rd04b");
    check("w0_cfg_r1", cfg[0][63:32], 32'h5A00AB00);
    check("w0_cfg_r0", cfg[0][31:0], 32'h0);

    // Reset during the wait phase of a write aborts it.
    cyc();
    sel     = 2'b10;
    HTRANSM = 2'b10;
    HADDRM  = 32'h00;
    HWRITEM = 1'b1;
    HSIZEM  = 3'b010;
    cyc();
    idle_bus();
    HWDATAM = 32'hFFFFFFFF;
    HRESET  = 1'b1;
    @(negedge HCLK);
    check("rst_mid_wait_ready", 32'(rdy[1]), 32'h0);
    cyc();
    HRESET = 1'b0;
    @(negedge HCLK);
    check("rst_mid_ready", 32'(rdy[1]), 32'h1);
    check("rst_mid_resp", 32'(resp[1]), 32'h0);
    check("rst_mid_cfg0", cfg[1][31:0], 32'h0);
    check("rst_mid_cfg2", cfg[1][95:64], 32'h0);
    check("rst_mid_pulse", 32'(pulse[1]), 32'h0);
    repeat (4) cyc();
    @(negedge HCLK);
    check("rst_mid_cfg0_later", cfg[1][31:0], 32'h0);
    check("rst_mid_ready_later", 32'(rdy[1]), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
